// File: rtl/ticket_txn_sequencer_if.sv
// Ticket machine transaction bus: customer buttons/coins in,
// registered selection, payment and status values out.
interface ticket_txn_sequencer_if;
    logic       path_1;
    logic       path_2;
    logic       pri_3;
    logic       pri_4;
    logic       pri_5;
    logic       qua_1;
    logic       qua_2;
    logic       COIN_5;
    logic       COIN_10;
    logic       FINISH;
    logic       CANCEL;
    logic [1:0] PATH;
    logic [2:0] PRI;
    logic [1:0] QUA;
    logic [3:0] COST;
    logic [7:0] COIN;
    logic [7:0] REST;
    logic       TICKET_ISSUED;
    logic       REFUND;
    logic       INSUFF;
    logic [2:0] STATE;

    modport master (
        output path_1, path_2, pri_3, pri_4, pri_5,
        output qua_1, qua_2, COIN_5, COIN_10, FINISH, CANCEL,
        input  PATH, PRI, QUA, COST, COIN, REST,
        input  TICKET_ISSUED, REFUND, INSUFF, STATE
    );

    modport slave (
        input  path_1, path_2, pri_3, pri_4, pri_5,
        input  qua_1, qua_2, COIN_5, COIN_10, FINISH, CANCEL,
        output PATH, PRI, QUA, COST, COIN, REST,
        output TICKET_ISSUED, REFUND, INSUFF, STATE
    );
endinterface

// File: rtl/ticket_txn_sequencer.sv
// Ticket machine transaction controller: selection, payment,
// dispense/refund, with cancel, inactivity timeout and overpay guard.
module ticket_txn_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [7:0]  COIN_MAX       = 8'd250
) (
    input  logic                   CLK,
    input  logic                   RD,
    ticket_txn_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEL_PRI  = 3'd1,
        S_SEL_QUA  = 3'd2,
        S_PAY      = 3'd3,
        S_DISPENSE = 3'd4,
        S_REFUND   = 3'd5
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [10:0] btn_w, prev_q, edg_w;
    logic [1:0]  path_q, path_d;
    logic [2:0]  pri_q, pri_d;
    logic [1:0]  qua_q, qua_d;
    logic [3:0]  cost_q, cost_d;
    logic [7:0]  coin_q, coin_d;
    logic [7:0]  rest_q, rest_d;
    logic        tick_q, tick_d;
    logic        refund_q, refund_d;
    logic        insuff_q, insuff_d;
    logic [15:0] cnt_q, cnt_d;

    logic e_p1, e_p2, e_r3, e_r4, e_r5, e_q1, e_q2;
    logic e_c5, e_c10, e_fin, e_can;
    logic [7:0] add_w;
    logic [8:0] sum_w;
    logic [7:0] coin_new_w;
    logic coin_acc_w, active_w, progress_w, tmo_w, abort_w, paid_w;

    assign btn_w = {bus.CANCEL, bus.FINISH, bus.COIN_10, bus.COIN_5,
                    bus.qua_2, bus.qua_1, bus.pri_5, bus.pri_4,
                    bus.pri_3, bus.path_2, bus.path_1};
    assign edg_w = btn_w & ~prev_q;

    assign e_p1  = edg_w[0];
    assign e_p2  = edg_w[1];
    assign e_r3  = edg_w[2];
    assign e_r4  = edg_w[3];
    assign e_r5  = edg_w[4];
    assign e_q1  = edg_w[5];
    assign e_q2  = edg_w[6];
    assign e_c5  = edg_w[7];
    assign e_c10 = edg_w[8];
    assign e_fin = edg_w[9];
    assign e_can = edg_w[10];

    // A coin add that would pass the ceiling is dropped whole.
    assign add_w      = (e_c5 ? 8'd5 : 8'd0) + (e_c10 ? 8'd10 : 8'd0);
    assign sum_w      = {1'b0, coin_q} + {1'b0, add_w};
    assign coin_acc_w = (add_w != 8'd0) && (sum_w <= {1'b0, COIN_MAX});
    assign coin_new_w = coin_acc_w ? sum_w[7:0] : coin_q;
    assign paid_w     = coin_new_w >= {4'd0, cost_q};

    assign active_w = (state_q == S_SEL_PRI) || (state_q == S_SEL_QUA)
                   || (state_q == S_PAY);

    assign progress_w =
        ((state_q == S_SEL_PRI) && (e_r3 || e_r4 || e_r5)) ||
        ((state_q == S_SEL_QUA) && (e_q1 || e_q2)) ||
        ((state_q == S_PAY) && (coin_acc_w || e_fin));

    assign tmo_w   = active_w && !progress_w && (cnt_q >= TMO_LAST);
    assign abort_w = active_w && (e_can || tmo_w);

    // State register.
    always_ff @(posedge CLK or posedge RD) begin
        if (RD) state_q <= S_IDLE;
        else    state_q <= state_d;
    end

    // Next-state decision; cancel and timeout beat everything else.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:
                if (e_p1 || e_p2) state_d = S_SEL_PRI;
            S_SEL_PRI:
                if (abort_w)                  state_d = S_REFUND;
                else if (e_r3 || e_r4 || e_r5) state_d = S_SEL_QUA;
            S_SEL_QUA:
                if (abort_w)           state_d = S_REFUND;
                else if (e_q1 || e_q2) state_d = S_PAY;
            S_PAY:
                if (abort_w)              state_d = S_REFUND;
                else if (e_fin && paid_w) state_d = S_DISPENSE;
            S_DISPENSE: state_d = S_IDLE;
            S_REFUND:   state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Next values of the selection, payment, pulse and timer registers.
    always_comb begin
        path_d   = path_q;
        pri_d    = pri_q;
        qua_d    = qua_q;
        cost_d   = cost_q;
        coin_d   = coin_q;
        rest_d   = rest_q;
        tick_d   = 1'b0;
        refund_d = 1'b0;
        insuff_d = 1'b0;

        if (!active_w || progress_w || state_d != state_q) cnt_d = 16'd0;
        else                                               cnt_d = cnt_q + 16'd1;

        if (abort_w) begin
            refund_d = 1'b1;
            rest_d   = coin_q;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (e_p1) begin
                        path_d = 2'd1;
                        rest_d = 8'd0;
                    end else if (e_p2) begin
                        path_d = 2'd2;
                        rest_d = 8'd0;
                    end
                end
                S_SEL_PRI: begin
                    if (e_r3)      pri_d = 3'd3;
                    else if (e_r4) pri_d = 3'd4;
                    else if (e_r5) pri_d = 3'd5;
                end
                S_SEL_QUA: begin
                    if (e_q1) begin
                        qua_d  = 2'd1;
                        cost_d = {1'b0, pri_q};
                    end else if (e_q2) begin
                        qua_d  = 2'd2;
                        cost_d = {pri_q, 1'b0};
                    end
                end
                S_PAY: begin
                    coin_d = coin_new_w;
                    if (e_fin && paid_w) begin
                        tick_d = 1'b1;
                        rest_d = coin_new_w - {4'd0, cost_q};
                    end else if (e_fin) begin
                        insuff_d = 1'b1;
                    end
                end
                S_DISPENSE, S_REFUND: begin
                    path_d = 2'd0;
                    pri_d  = 3'd0;
                    qua_d  = 2'd0;
                    cost_d = 4'd0;
                    coin_d = 8'd0;
                end
                default: ;
            endcase
        end
    end

    // Datapath, pulse and edge-detector registers.
    always_ff @(posedge CLK or posedge RD) begin
        if (RD) begin
            prev_q   <= '0;
            path_q   <= '0;
            pri_q    <= '0;
            qua_q    <= '0;
            cost_q   <= '0;
            coin_q   <= '0;
            rest_q   <= '0;
            tick_q   <= 1'b0;
            refund_q <= 1'b0;
            insuff_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            prev_q   <= btn_w;
            path_q   <= path_d;
            pri_q    <= pri_d;
            qua_q    <= qua_d;
            cost_q   <= cost_d;
            coin_q   <= coin_d;
            rest_q   <= rest_d;
            tick_q   <= tick_d;
            refund_q <= refund_d;
            insuff_q <= insuff_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.PATH          = path_q;
    assign bus.PRI           = pri_q;
    assign bus.QUA           = qua_q;
    assign bus.COST          = cost_q;
    assign bus.COIN          = coin_q;
    assign bus.REST          = rest_q;
    assign bus.TICKET_ISSUED = tick_q;
    assign bus.REFUND        = refund_q;
    assign bus.INSUFF        = insuff_q;
    assign bus.STATE         = state_q;

endmodule

// File: tb/tb_ticket_txn_sequencer.sv
// Bench for ticket_txn_sequencer: transaction-level model compared
// every cycle, plus hand-computed checks on directed scenarios.
module tb_ticket_txn_sequencer;

    localparam int TMO = 8;

    localparam logic [10:0] P1  = 11'h001;
    localparam logic [10:0] P2  = 11'h002;
    localparam logic [10:0] R3  = 11'h004;
    localparam logic [10:0] R4  = 11'h008;
    localparam logic [10:0] R5  = 11'h010;
    localparam logic [10:0] Q1  = 11'h020;
    localparam logic [10:0] Q2  = 11'h040;
    localparam logic [10:0] C5  = 11'h080;
    localparam logic [10:0] C10 = 11'h100;
    localparam logic [10:0] FIN = 11'h200;
    localparam logic [10:0] CAN = 11'h400;

    logic        CLK = 1'b0;
    logic        RD  = 1'b1;
    logic [10:0] btn = '0;

    int n_vec = 0;
    int n_bad = 0;

    ticket_txn_sequencer_if bus ();

    assign bus.path_1  = btn[0];
    assign bus.path_2  = btn[1];
    assign bus.pri_3   = btn[2];
    assign bus.pri_4   = btn[3];
    assign bus.pri_5   = btn[4];
    assign bus.qua_1   = btn[5];
    assign bus.qua_2   = btn[6];
    assign bus.COIN_5  = btn[7];
    assign bus.COIN_10 = btn[8];
    assign bus.FINISH  = btn[9];
    assign bus.CANCEL  = btn[10];

    ticket_txn_sequencer #(
        .TIMEOUT_CYCLES(TMO),
        .COIN_MAX(8'd250)
    ) dut (
        .CLK(CLK),
        .RD(RD),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    // phase: 0 idle, 1 pick price, 2 pick qty, 3 paying, 4 dispense, 5 refund
    typedef struct packed {
        int phase;
        int path;
        int pri;
        int qua;
        int cost;
        int coin;
        int rest;
        int tick;
        int refund;
        int insuff;
        int idle;
    } mdl_t;

    mdl_t        m    = '0;
    logic [10:0] prev = '0;

    function automatic mdl_t step(input mdl_t cur, input logic [10:0] e);
        mdl_t n;
        int   add;
        int   p;
        int   q;
        bit   prog;
        n = cur;
        n.tick = 0;
        n.refund = 0;
        n.insuff = 0;
        prog = 0;
        case (cur.phase)
            0: begin
                if (e[0] || e[1]) begin
                    n.path = e[0] ? 1 : 2;
                    n.rest = 0;
                    n.phase = 1;
                    n.idle = 0;
                end
            end
            1, 2, 3: begin
                if (e[10]) begin
                    n.refund = 1;
                    n.rest = cur.coin;
                    n.phase = 5;
                    n.idle = 0;
                end else begin
                    if (cur.phase == 1) begin
                        p = e[2] ? 3 : e[3] ? 4 : e[4] ? 5 : 0;
                        if (p != 0) begin
                            n.pri = p;
                            n.phase = 2;
                            prog = 1;
                        end
                    end else if (cur.phase == 2) begin
                        q = e[5] ? 1 : e[6] ? 2 : 0;
                        if (q != 0) begin
                            n.qua = q;
                            n.cost = cur.pri * q;
                            n.phase = 3;
                            prog = 1;
                        end
                    end else begin
                        add = (e[7] ? 5 : 0) + (e[8] ? 10 : 0);
                        if (add > 0 && cur.coin + add <= 250) begin
                            n.coin = cur.coin + add;
                            prog = 1;
                        end
                        if (e[9]) begin
                            prog = 1;
                            if (n.coin >= cur.cost) begin
                                n.tick = 1;
                                n.rest = n.coin - cur.cost;
                                n.phase = 4;
                            end else begin
                                n.insuff = 1;
                            end
                        end
                    end
                    if (prog) begin
                        n.idle = 0;
                    end else begin
                        n.idle = cur.idle + 1;
                        if (n.idle == TMO) begin
                            n.refund = 1;
                            n.rest = cur.coin;
                            n.phase = 5;
                            n.idle = 0;
                        end
                    end
                end
            end
            default: begin
                n = '0;
                n.rest = cur.rest;
            end
        endcase
        return n;
    endfunction

    function automatic logic [32:0] pack_mdl(input mdl_t x);
        logic [32:0] v;
        v = {x.path[1:0], x.pri[2:0], x.qua[1:0], x.cost[3:0],
             x.coin[7:0], x.rest[7:0], x.tick[0], x.refund[0],
             x.insuff[0], x.phase[2:0]};
        return v;
    endfunction

    logic [32:0] dut_vec;
    assign dut_vec = {bus.PATH, bus.PRI, bus.QUA, bus.COST, bus.COIN,
                      bus.REST, bus.TICKET_ISSUED, bus.REFUND,
                      bus.INSUFF, bus.STATE};

    // Reference model advances on the same edges as the design.
    initial forever begin
        @(posedge CLK or posedge RD);
        if (RD) begin
            m = '0;
            prev = '0;
        end else begin
            m = step(m, btn & ~prev);
            prev = btn;
        end
    end

    // Every-cycle compare, away from the rising edge.
    initial forever begin
        @(negedge CLK);
        n_vec++;
        if (dut_vec !== pack_mdl(m)) begin
            n_bad++;
            $display("FAIL cycle t=%0t got=%h exp=%h", $time,
                     dut_vec, pack_mdl(m));
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s got %0d exp %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse(input logic [10:0] b);
        btn = b;
        tick();
        btn = '0;
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk("rst_state", int'(bus.STATE), 0);
        chk("rst_coin", int'(bus.COIN), 0);
        chk("rst_rest", int'(bus.REST), 0);
        chk("rst_ticket", int'(bus.TICKET_ISSUED), 0);
        RD = 1'b0;

        // 1: path 2, price 4, qty 1, one 10-coin
        pulse(P2);
        pulse(R4);
        pulse(Q1);
        chk("s1_cost", int'(bus.COST), 4);
        pulse(C10);
        btn = FIN;
        tick();
        chk("s1_ticket", int'(bus.TICKET_ISSUED), 1);
        chk("s1_rest", int'(bus.REST), 6);
        chk("s1_state", int'(bus.STATE), 4);
        btn = '0;
        tick();
        chk("s1_idle", int'(bus.STATE), 0);
        chk("s1_coin_clr", int'(bus.COIN), 0);
        chk("s1_rest_held", int'(bus.REST), 6);

        // 2: cost 6, pay 25
        pulse(P1);
        pulse(R3);
        pulse(Q2);
        pulse(C5);
        pulse(C5);
        pulse(C5);
        pulse(C10);
        chk("s2_coin", int'(bus.COIN), 25);
        chk("s2_cost", int'(bus.COST), 6);
        btn = FIN;
        tick();
        chk("s2_rest", int'(bus.REST), 19);
        btn = '0;
        tick();

        // 3: cost 10, short then exact with coin+finish together
        pulse(P1);
        pulse(R5);
        pulse(Q2);
        pulse(C5);
        btn = FIN;
        tick();
        chk("s3_insuff", int'(bus.INSUFF), 1);
        chk("s3_stay", int'(bus.STATE), 3);
        btn = '0;
        tick();
        chk("s3_insuff_off", int'(bus.INSUFF), 0);
        btn = C5 | FIN;
        tick();
        chk("s3_ticket", int'(bus.TICKET_ISSUED), 1);
        chk("s3_rest", int'(bus.REST), 0);
        btn = '0;
        tick();

        // 4: cancel with 15 paid
        pulse(P1);
        pulse(R3);
        pulse(Q1);
        pulse(C5);
        pulse(C10);
        btn = CAN;
        tick();
        chk("s4_refund", int'(bus.REFUND), 1);
        chk("s4_rest", int'(bus.REST), 15);
        btn = '0;
        tick();
        chk("s4_idle", int'(bus.STATE), 0);
        chk("s4_coin", int'(bus.COIN), 0);

        // 5: timeout after path select
        btn = P2;
        tick();
        btn = '0;
        repeat (7) tick();
        chk("s5_wait", int'(bus.STATE), 1);
        tick();
        chk("s5_tmo_state", int'(bus.STATE), 5);
        chk("s5_tmo_refund", int'(bus.REFUND), 1);
        chk("s5_tmo_rest", int'(bus.REST), 0);
        tick();

        // coin ceiling: 15 both-at-once, up to 250, then rejects
        pulse(P2);
        pulse(R3);
        pulse(Q1);
        pulse(C5 | C10);
        chk("cap_both", int'(bus.COIN), 15);
        for (int i = 0; i < 23; i++) pulse(C10);
        pulse(C5);
        chk("cap_250", int'(bus.COIN), 250);
        pulse(C10);
        chk("cap_rej10", int'(bus.COIN), 250);
        pulse(C5 | C10);
        chk("cap_rej15", int'(bus.COIN), 250);
        btn = FIN;
        tick();
        chk("cap_rest", int'(bus.REST), 247);
        btn = '0;
        tick();

        // held coin counts once, then async reset mid-PAY
        pulse(P1);
        pulse(R3);
        pulse(Q1);
        btn = C10;
        repeat (3) tick();
        btn = '0;
        tick();
        chk("hold_coin", int'(bus.COIN), 10);
        #2;
        RD = 1'b1;
        #1;
        chk("ar_state", int'(bus.STATE), 0);
        chk("ar_coin", int'(bus.COIN), 0);
        chk("ar_path", int'(bus.PATH), 0);
        chk("ar_refund", int'(bus.REFUND), 0);
        tick();
        RD = 1'b0;
        btn = P1 | R3;
        tick();
        chk("conf_path", int'(bus.PATH), 1);
        chk("conf_pri", int'(bus.PRI), 0);
        chk("conf_state", int'(bus.STATE), 1);
        btn = '0;
        tick();
        pulse(CAN);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
